// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing with pixel enable, frame and game-update pulses.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int TICK_FRAMES = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       pixel_en,
  output logic       frame_tick,
  output logic       move_tick
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int FW = TICK_FRAMES > 1 ? $clog2(TICK_FRAMES) : 1;
  logic [DW-1:0] div;
  logic [FW-1:0] fcnt;
  logic [9:0] h_nx, v_nx;
  logic adv, h_end, v_end, ft, f_last;
  // Sync and bright are derived from the next counts so they line up with hCount/vCount.
  always_comb begin
    adv = div == DW'(CLK_DIV - 1);
    h_end = hCount == 10'(H_TOTAL - 1);
    v_end = vCount == 10'(V_TOTAL - 1);
    h_nx = !adv ? hCount : h_end ? '0 : hCount + 10'd1;
    v_nx = !(adv && h_end) ? vCount : v_end ? '0 : vCount + 10'd1;
    ft = adv && h_end && v_nx == 10'(V_START + V_ACTIVE);
    f_last = fcnt == FW'(TICK_FRAMES - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      fcnt <= '0;
      hCount <= '0;
      vCount <= '0;
      hSync <= 1'b0;
      vSync <= 1'b0;
      bright <= 1'b0;
      pixel_en <= 1'b0;
      frame_tick <= 1'b0;
      move_tick <= 1'b0;
    end else begin
      div <= adv ? '0 : div + DW'(1);
      fcnt <= ft ? (f_last ? '0 : fcnt + FW'(1)) : fcnt;
      hCount <= h_nx;
      vCount <= v_nx;
      hSync <= h_nx >= 10'(H_SYNC);
      vSync <= v_nx >= 10'(V_SYNC);
      bright <= h_nx >= 10'(H_START) && h_nx < 10'(H_START + H_ACTIVE)
             && v_nx >= 10'(V_START) && v_nx < 10'(V_START + V_ACTIVE);
      pixel_en <= adv;
      frame_tick <= ft;
      move_tick <= ft && f_last;
    end
  end
endmodule
